// File: rtl/vc_val_rdy_rr_arbiter.sv
// Round-robin merge of p_num_reqs val/rdy streams into one registered val/rdy
// output. Each buffered message carries the index of the requester it came from.
module vc_val_rdy_rr_arbiter #(
    parameter int p_num_reqs = 4,
    parameter int p_msg_sz   = 8,
    parameter int p_src_sz   = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [p_num_reqs-1:0]          in_val,
    output logic [p_num_reqs-1:0]          in_rdy,
    input  logic [p_num_reqs*p_msg_sz-1:0] in_msg,
    output logic                           out_val,
    input  logic                           out_rdy,
    output logic [p_msg_sz-1:0]            out_msg,
    output logic [p_src_sz-1:0]            out_src,
    output logic [15:0]                    count
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t                  r_state;
    logic [p_msg_sz-1:0]     r_msg;
    logic [p_src_sz-1:0]     r_src;
    logic [p_src_sz-1:0]     r_prio;
    logic [15:0]             r_count;

    logic                    w_acc;
    logic                    w_found;
    logic [p_num_reqs-1:0]   w_gnt;
    logic [p_src_sz-1:0]     w_idx;
    logic [p_src_sz-1:0]     w_prio_nxt;
    logic [p_msg_sz-1:0]     w_msg;

    // The register can take a new message when empty or when it drains this cycle.
    assign w_acc = (r_state == EMPTY) || out_rdy;

    // Search prio..N-1 first, then 0..prio-1, so the scan wraps from prio.
    always_comb begin
        w_gnt   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        w_msg   = '0;
        if (w_acc && reset) begin
            for (int i = 0; i < p_num_reqs; i++) begin
                if (!w_found && i >= int'(r_prio) && in_val[i]) begin
                    w_found  = 1'b1;
                    w_gnt[i] = 1'b1;
                    w_idx    = p_src_sz'(i);
                    w_msg    = in_msg[i*p_msg_sz +: p_msg_sz];
                end
            end
            for (int i = 0; i < p_num_reqs; i++) begin
                if (!w_found && i < int'(r_prio) && in_val[i]) begin
                    w_found  = 1'b1;
                    w_gnt[i] = 1'b1;
                    w_idx    = p_src_sz'(i);
                    w_msg    = in_msg[i*p_msg_sz +: p_msg_sz];
                end
            end
        end
    end

    assign w_prio_nxt = (int'(w_idx) == p_num_reqs - 1) ? '0 : w_idx + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= EMPTY;
            r_msg   <= '0;
            r_src   <= '0;
            r_prio  <= '0;
            r_count <= '0;
        end else if (w_found) begin
            r_state <= FULL;
            r_msg   <= w_msg;
            r_src   <= w_idx;
            r_prio  <= w_prio_nxt;
            r_count <= r_count + 16'd1;
        end else if (out_rdy) begin
            r_state <= EMPTY;
        end
    end

    assign in_rdy  = w_gnt;
    assign out_val = (r_state == FULL);
    assign out_msg = r_msg;
    assign out_src = r_src;
    assign count   = r_count;

endmodule

// File: tb/tb_vc_val_rdy_rr_arbiter.sv
// Scoreboard bench for the round-robin val/rdy arbiter: directed vectors push
// expected (src,msg) pairs; a monitor pops them as the output handshakes.
module tb_vc_val_rdy_rr_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  in_val;
    logic [3:0]  in_rdy;
    logic [31:0] in_msg;
    logic        out_val;
    logic        out_rdy;
    logic [7:0]  out_msg;
    logic [1:0]  out_src;
    logic [15:0] count;

    typedef struct packed {
        logic [1:0] src;
        logic [7:0] msg;
    } exp_t;

    exp_t q[$];
    bit   ordered;
    int   n_checks = 0;
    int   n_errors = 0;
    int   rx = 0;

    vc_val_rdy_rr_arbiter #(.p_num_reqs(4), .p_msg_sz(8), .p_src_sz(2)) dut (
        .clk     (clk),
        .reset   (reset),
        .in_val  (in_val),
        .in_rdy  (in_rdy),
        .in_msg  (in_msg),
        .out_val (out_val),
        .out_rdy (out_rdy),
        .out_msg (out_msg),
        .out_src (out_src),
        .count   (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input int s, input logic [7:0] m);
        exp_t e;
        e.src = 2'(s);
        e.msg = m;
        q.push_back(e);
    endtask

    // In ordered mode the head must match; otherwise the oldest entry of that source.
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (reset && out_val && out_rdy) begin
                int idx;
                idx = -1;
                if (ordered) begin
                    if (q.size() > 0) idx = 0;
                end else begin
                    for (int i = 0; i < q.size(); i++)
                        if (idx < 0 && q[i].src == out_src) idx = i;
                end
                rx++;
                if (idx < 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_out: got src %0d msg %0h expected none", out_src, out_msg);
                end else begin
                    chk("out_src", 32'(out_src), 32'(q[idx].src));
                    chk("out_msg", 32'(out_msg), 32'(q[idx].msg));
                    q.delete(idx);
                end
            end
        end
    endtask

    task automatic cyc(input logic [3:0] v, input logic [31:0] m, input logic ordy);
        @(posedge clk);
        #1;
        in_val  = v;
        in_msg  = m;
        out_rdy = ordy;
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(4'h0, 32'h0, 1'b1);
        chk("leftover", 32'(q.size()), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset   = 1'b0;
        in_val  = '0;
        out_rdy = 1'b0;
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        int sent[4];
        int dly[4];
        int ncyc;
        logic [3:0] fire;

        reset   = 1'b0;
        in_val  = 4'hf;
        in_msg  = 32'h13121110;
        out_rdy = 1'b1;
        ordered = 1'b1;
        fork monitor(); join_none

        // Reset state: no grant even with every requester valid.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_rdy", 32'(in_rdy), 32'h0);
        chk("rst_out_val", 32'(out_val), 32'h0);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_out_msg", 32'(out_msg), 32'h0);
        chk("rst_out_src", 32'(out_src), 32'h0);
        in_val = '0;
        reset  = 1'b1;

        // 1. single stream from req0
        do_reset();
        push(0, 8'haa); push(0, 8'hbb); push(0, 8'hcc);
        cyc(4'b0001, 32'h000000aa, 1'b1); chk("t1_rdy0", 32'(in_rdy), 32'h1);
        cyc(4'b0001, 32'h000000bb, 1'b1); chk("t1_rdy1", 32'(in_rdy), 32'h1);
        cyc(4'b0001, 32'h000000cc, 1'b1); chk("t1_rdy2", 32'(in_rdy), 32'h1);
        idle(3);
        chk("t1_count", 32'(count), 32'd3);
        chk("t1_out_val", 32'(out_val), 32'h0);

        // 2. all four valid: strict rotation 0,1,2,3,...
        do_reset();
        for (int k = 0; k < 8; k++) push(k % 4, 8'(8'h10 + k % 4));
        for (int k = 0; k < 8; k++) begin
            cyc(4'hf, 32'h13121110, 1'b1);
            chk("t2_rdy", 32'(in_rdy), 32'(1 << (k % 4)));
        end
        idle(3);
        chk("t2_count", 32'(count), 32'd8);

        // 3. backpressure while FULL, then drain and enqueue in the same cycle
        do_reset();
        push(0, 8'h30); push(2, 8'h32);
        cyc(4'b0001, 32'h00000030, 1'b0); chk("t3_rdy_first", 32'(in_rdy), 32'h1);
        for (int k = 0; k < 5; k++) begin
            cyc(4'b0100, 32'h00320000, 1'b0);
            chk("t3_bp_rdy", 32'(in_rdy), 32'h0);
            chk("t3_bp_val", 32'(out_val), 32'h1);
            chk("t3_bp_msg", 32'(out_msg), 32'h30);
            chk("t3_bp_src", 32'(out_src), 32'h0);
        end
        cyc(4'b0100, 32'h00320000, 1'b1);
        chk("t3_rel_rdy", 32'(in_rdy), 32'h4);
        idle(3);
        chk("t3_count", 32'(count), 32'd2);

        // 4. sparse: req1 primes prio to 2, then req3,req1,req3
        do_reset();
        push(1, 8'h40); push(3, 8'h43); push(1, 8'h41); push(3, 8'h43);
        cyc(4'b0010, 32'h00004000, 1'b1); chk("t4_prime", 32'(in_rdy), 32'h2);
        cyc(4'b1010, 32'h43004100, 1'b1); chk("t4_g0", 32'(in_rdy), 32'h8);
        cyc(4'b1010, 32'h43004100, 1'b1); chk("t4_g1", 32'(in_rdy), 32'h2);
        cyc(4'b1010, 32'h43004100, 1'b1); chk("t4_g2", 32'(in_rdy), 32'h8);
        idle(3);

        // 5. reset while FULL drops the buffered message and prio
        do_reset();
        cyc(4'b0100, 32'h00550000, 1'b0); chk("t5_rdy", 32'(in_rdy), 32'h4);
        cyc(4'b0000, 32'h0, 1'b0);
        chk("t5_full", 32'(out_val), 32'h1);
        chk("t5_cnt1", 32'(count), 32'd1);
        chk("t5_msg", 32'(out_msg), 32'h55);
        @(posedge clk);
        #1;
        in_val = 4'hf;
        reset  = 1'b0;
        #1;
        chk("t5_rst_val", 32'(out_val), 32'h0);
        chk("t5_rst_cnt", 32'(count), 32'h0);
        chk("t5_rst_rdy", 32'(in_rdy), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        in_val = '0;
        reset  = 1'b1;
        idle(2);
        push(0, 8'h60);
        cyc(4'hf, 32'h63626160, 1'b1); chk("t5_first", 32'(in_rdy), 32'h1);
        idle(3);

        // 6. four random-delay sources, six messages each, random sink stalls
        do_reset();
        ordered = 1'b0;
        rx = 0;
        ncyc = 0;
        for (int s = 0; s < 4; s++) begin
            sent[s] = 0;
            dly[s]  = int'($urandom_range(0, 2));
        end
        while ((sent[0] < 6 || sent[1] < 6 || sent[2] < 6 || sent[3] < 6 || q.size() > 0)
               && ncyc < 1000) begin
            @(negedge clk);
            fire = in_val & in_rdy;
            @(posedge clk);
            #1;
            ncyc++;
            for (int s = 0; s < 4; s++) begin
                if (fire[s]) begin
                    sent[s]++;
                    dly[s]    = int'($urandom_range(0, 2));
                    in_val[s] = 1'b0;
                end
                if (!in_val[s] && sent[s] < 6) begin
                    if (dly[s] == 0) begin
                        in_val[s]         = 1'b1;
                        in_msg[s*8 +: 8]  = 8'(s * 16 + sent[s]);
                        push(s, 8'(s * 16 + sent[s]));
                    end else begin
                        dly[s]--;
                    end
                end
            end
            out_rdy = ($urandom_range(0, 3) != 0);
        end
        if (ncyc >= 1000) begin
            n_checks++;
            n_errors++;
            $display("FAIL t6_timeout: got %0d cycles expected completion", ncyc);
        end
        idle(3);
        chk("t6_rx", 32'(rx), 32'd24);
        chk("t6_count", 32'(count), 32'd24);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
